key_search_scheduler: RTL and testbench
=======================================

KEY_SEARCH_SCHEDULER -- requirements
Module: key_search_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of decrypt cores served (1..16).
REQ-002 SHALL have parameter KEY_WIDTH, default 24, secret key width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  sync active-high reset.
- start  in  1  level; sampled only in IDLE.
- stop  in  1  external abort.
- done  out  1  search finished.
- done_ack  in  1  releases DONE.
- key_start_value  in  KEY_WIDTH  first key, inclusive.
- key_end_value  in  KEY_WIDTH  last key, inclusive.
- found  out  1  valid with done.
- found_key  out  KEY_WIDTH  valid when found.
- keys_dispatched  out  KEY_WIDTH+1  count of grants this search.
- core_req  in  NUM_CORES  core idle, wants a key.
- core_grant  out  NUM_CORES  one-hot, one-cycle pulse.
- core_key  out  KEY_WIDTH  key for granted core, valid with core_grant.
- core_result_valid  in  NUM_CORES  one-cycle pulse, core finished its key.
- core_result_found  in  NUM_CORES  qualifies core_result_valid.
- core_abort  out  1  one-cycle pulse, all cores drop work.

Function
REQ-005 SHALL implement states IDLE, DISPATCH, DRAIN, DONE.
REQ-006 IDLE: on start=1, SHALL latch key range, load next_key=key_start_value into a KEY_WIDTH+1 counter, clear busy bits, found, keys_dispatched; go DISPATCH next cycle.
REQ-007 IDLE with key_end_value < key_start_value SHALL go directly to DONE, found=0, no grants.
REQ-008 DISPATCH: each cycle SHALL grant at most one core among those with core_req=1 and busy=0, round-robin starting after the last granted index.
REQ-009 Grant SHALL be registered: core_grant and core_key=next_key appear the cycle after the qualifying core_req is sampled.
REQ-010 On grant, SHALL set busy[i], store assigned_key[i]=next_key, increment next_key and keys_dispatched.
REQ-011 When next_key > key_end_value, SHALL stop granting and go DRAIN; key_end_value = all-ones SHALL terminate without wrap.
REQ-012 core_result_valid[i] SHALL clear busy[i]; a core may be regranted no earlier than the following cycle.
REQ-013 DRAIN: when all busy bits clear and no found, SHALL go DONE with found=0.
REQ-014 In DISPATCH or DRAIN, core_result_valid[i]&core_result_found[i] SHALL latch found=1, found_key=assigned_key[i], pulse core_abort, go DONE.
REQ-015 Simultaneous found from several cores SHALL select the lowest index.
REQ-016 Found and grant in the same cycle: found SHALL win; grant suppressed.
REQ-017 stop=1 in DISPATCH/DRAIN SHALL pulse core_abort, go DONE, found=0; found in same cycle takes priority over stop.
REQ-018 DONE: done=1, outputs held stable until done_ack=1, then IDLE next cycle; done=0 in all other states.
REQ-019 Results from cores not busy SHALL be ignored.

Reset
REQ-020 reset SHALL force IDLE, done=0, found=0, found_key=0, keys_dispatched=0, core_grant=0, core_key=0, core_abort=0, busy=0, round-robin pointer=0, mid-search included.

Structure
REQ-021 State enum and default NUM_CORES/KEY_WIDTH SHALL live in shared package key_search_pkg.
REQ-022 Round-robin selection SHALL be sub-module rr_arbiter (parameter N; request, enable, one-hot grant, pointer update on grant).

Verification
REQ-023 Range 0..3, 4 cores all requesting, no find -> grants cores 0,1,2,3 with keys 0,1,2,3 on consecutive cycles; done found=0; keys_dispatched=4.
REQ-024 Range 0x10..0x1F, core 2 reports found on its second key -> found_key equals that assigned key, core_abort one pulse, no further grants.
REQ-025 Cores 1 and 3 report found same cycle -> found_key=assigned_key[1].
REQ-026 key_start=0xFFFFFE, key_end=0xFFFFFF -> exactly 2 grants, no wrap, done found=0.
REQ-027 stop asserted mid-DISPATCH -> core_abort pulse, done found=0; done held until done_ack, then IDLE.
REQ-028 reset asserted in DRAIN -> all outputs at reset values next cycle; new start runs normally.

Source files
------------

// File: rtl/key_search_pkg.sv
// Shared types and defaults for the key search scheduler slice.
package key_search_pkg;

  localparam int unsigned DEF_NUM_CORES = 4;
  localparam int unsigned DEF_KEY_WIDTH = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/key_search_scheduler_if.sv
// Core-side bus of the key search scheduler: key hand-out, results and abort.
interface key_search_scheduler_if
  import key_search_pkg::*;
#(
  parameter int unsigned NUM_CORES = DEF_NUM_CORES,
  parameter int unsigned KEY_WIDTH = DEF_KEY_WIDTH
);

  logic [NUM_CORES-1:0] core_req;
  logic [NUM_CORES-1:0] core_grant;
  logic [KEY_WIDTH-1:0] core_key;
  logic [NUM_CORES-1:0] core_result_valid;
  logic [NUM_CORES-1:0] core_result_found;
  logic                 core_abort;

  modport master (
    input  core_req,
    input  core_result_valid,
    input  core_result_found,
    output core_grant,
    output core_key,
    output core_abort
  );

  modport slave (
    output core_req,
    output core_result_valid,
    output core_result_found,
    input  core_grant,
    input  core_key,
    input  core_abort
  );

endinterface

// File: rtl/key_search_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, priority resumes just
// after the most recently granted index.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] request,
  input  logic         enable,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [N-1:0]  mask;
  logic [N-1:0]  masked;
  logic [N-1:0]  pick_src;

  // Requests at or above ptr take precedence; fall back to the full set to wrap.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mask[i] = (PW'(i) >= ptr);
    end
    masked   = request & mask;
    pick_src = (|masked) ? masked : request;
    grant    = enable ? (pick_src & (~pick_src + N'(1))) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (|grant) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (grant[i]) begin
          ptr <= (i == N - 1) ? '0 : PW'(i + 1);
        end
      end
    end
  end

endmodule

// File: rtl/key_search_scheduler.sv
// Hands out keys of an inclusive range to a pool of decrypt cores and stops
// the search on the first reported hit, an external stop, or exhaustion.
module key_search_scheduler
  import key_search_pkg::*;
#(
  parameter int unsigned NUM_CORES = DEF_NUM_CORES,
  parameter int unsigned KEY_WIDTH = DEF_KEY_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  output logic                 done,
  input  logic                 done_ack,
  input  logic [KEY_WIDTH-1:0] key_start_value,
  input  logic [KEY_WIDTH-1:0] key_end_value,
  output logic                 found,
  output logic [KEY_WIDTH-1:0] found_key,
  output logic [KEY_WIDTH:0]   keys_dispatched,
  key_search_scheduler_if.master core
);

  state_t               state;
  logic [KEY_WIDTH-1:0] end_q;
  logic [KEY_WIDTH:0]   next_key;
  logic [NUM_CORES-1:0] busy;
  logic [KEY_WIDTH-1:0] assigned_key [NUM_CORES];

  logic [NUM_CORES-1:0] valid_q;
  logic [NUM_CORES-1:0] hits;
  logic [NUM_CORES-1:0] hit_sel;
  logic [KEY_WIDTH-1:0] hit_key;
  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] arb_grant;
  logic                 exhausted;
  logic                 arb_en;

  // The extra counter bit lets an all-ones end value terminate instead of wrapping.
  assign exhausted = next_key > {1'b0, end_q};
  assign valid_q   = core.core_result_valid & busy;
  assign hits      = valid_q & core.core_result_found;
  assign hit_sel   = hits & (~hits + NUM_CORES'(1));
  assign eligible  = core.core_req & ~busy;
  assign arb_en    = (state == ST_DISPATCH) && !exhausted && (hits == '0) && !stop;
  assign done      = (state == ST_DONE);

  always_comb begin
    hit_key = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (hit_sel[i]) begin
        hit_key = assigned_key[i];
      end
    end
  end

  rr_arbiter #(
    .N(NUM_CORES)
  ) u_rr_arbiter (
    .clk    (clk),
    .reset  (reset),
    .request(eligible),
    .enable (arb_en),
    .grant  (arb_grant)
  );

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (arb_grant[i]) begin
        assigned_key[i] <= next_key[KEY_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      end_q           <= '0;
      next_key        <= '0;
      busy            <= '0;
      found           <= 1'b0;
      found_key       <= '0;
      keys_dispatched <= '0;
      core.core_grant <= '0;
      core.core_key   <= '0;
      core.core_abort <= 1'b0;
    end else begin
      core.core_grant <= '0;
      core.core_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            end_q           <= key_end_value;
            next_key        <= {1'b0, key_start_value};
            busy            <= '0;
            found           <= 1'b0;
            keys_dispatched <= '0;
            state           <= (key_end_value < key_start_value) ? ST_DONE : ST_DISPATCH;
          end
        end
        ST_DISPATCH, ST_DRAIN: begin
          // A hit outranks stop, and both suppress any grant this cycle.
          if (|hits) begin
            found           <= 1'b1;
            found_key       <= hit_key;
            core.core_abort <= 1'b1;
            busy            <= '0;
            state           <= ST_DONE;
          end else if (stop) begin
            core.core_abort <= 1'b1;
            busy            <= '0;
            state           <= ST_DONE;
          end else begin
            busy <= (busy & ~valid_q) | arb_grant;
            if (|arb_grant) begin
              core.core_grant <= arb_grant;
              core.core_key   <= next_key[KEY_WIDTH-1:0];
              next_key        <= next_key + (KEY_WIDTH + 1)'(1);
              keys_dispatched <= keys_dispatched + (KEY_WIDTH + 1)'(1);
            end
            if ((state == ST_DISPATCH) && exhausted) begin
              state <= ST_DRAIN;
            end
            if ((state == ST_DRAIN) && (busy == '0)) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (done_ack) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_search_scheduler.sv
// Self-checking bench: emulated cores with random latency against a
// cycle-level behavioural model of the scheduler.
module tb_key_search_scheduler;
  import key_search_pkg::*;

  localparam int NC = DEF_NUM_CORES;
  localparam int KW = DEF_KEY_WIDTH;

  logic          clk = 1'b0;
  logic          reset, start, stop, done_ack;
  logic          done, found;
  logic [KW-1:0] ks, ke, found_key;
  logic [KW:0]   keys_dispatched;

  int n_vec = 0;
  int n_err = 0;

  key_search_scheduler_if #(.NUM_CORES(NC), .KEY_WIDTH(KW)) cif ();

  key_search_scheduler #(.NUM_CORES(NC), .KEY_WIDTH(KW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .done(done),
    .done_ack(done_ack), .key_start_value(ks), .key_end_value(ke),
    .found(found), .found_key(found_key), .keys_dispatched(keys_dispatched),
    .core(cif)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 handing out keys, 2 waiting for cores, 3 finished.
  int              m_phase, m_last;
  longint unsigned m_next, m_end, m_disp;
  bit [NC-1:0]     m_busy;
  logic [KW-1:0]   m_assigned [NC];
  bit              m_found;
  logic [KW-1:0]   m_fkey;
  bit [NC-1:0]     e_grant;
  bit              e_abort;
  logic [KW-1:0]   e_key;

  // Core emulation knobs and state.
  int            req_pct, lat_lo, lat_hi;
  bit            sec_en, spurious;
  logic [KW-1:0] sec0, sec1;
  bit            c_work [NC];
  int            c_cnt [NC];
  logic [KW-1:0] c_key [NC];

  task automatic model_reset();
    m_phase = 0; m_last = NC - 1; m_next = 0; m_end = 0; m_disp = 0;
    m_busy = '0; m_found = 0; m_fkey = '0; e_grant = '0; e_abort = 0; e_key = '0;
    for (int i = 0; i < NC; i++) m_assigned[i] = '0;
  endtask

  task automatic model_step();
    bit [NC-1:0] vld, hits, elig;
    int pick;
    bit was_empty;
    e_grant = '0; e_abort = 0;
    vld  = cif.core_result_valid & m_busy;
    hits = vld & cif.core_result_found;
    elig = cif.core_req & ~m_busy;
    case (m_phase)
      0: if (start) begin
        m_found = 0; m_disp = 0; m_busy = '0; m_next = ks; m_end = ke;
        m_phase = (ke < ks) ? 3 : 1;
      end
      1, 2: begin
        if (hits != 0) begin
          pick = -1;
          for (int i = 0; i < NC; i++) if (pick < 0 && hits[i]) pick = i;
          m_found = 1; m_fkey = m_assigned[pick]; e_abort = 1; m_busy = '0; m_phase = 3;
        end else if (stop) begin
          e_abort = 1; m_busy = '0; m_phase = 3;
        end else begin
          was_empty = (m_busy == 0);
          m_busy = m_busy & ~vld;
          if (m_phase == 1) begin
            if (m_next > m_end) m_phase = 2;
            else begin
              pick = -1;
              for (int k = 1; k <= NC; k++)
                if (pick < 0 && elig[(m_last + k) % NC]) pick = (m_last + k) % NC;
              if (pick >= 0) begin
                e_grant[pick] = 1; e_key = KW'(m_next); m_assigned[pick] = KW'(m_next);
                m_busy[pick] = 1; m_next++; m_disp++; m_last = pick;
              end
            end
          end else if (was_empty) m_phase = 3;
        end
      end
      default: if (done_ack) m_phase = 0;
    endcase
  endtask

  task automatic drive_cores();
    for (int i = 0; i < NC; i++) begin
      cif.core_result_valid[i] = 1'b0;
      cif.core_result_found[i] = 1'b0;
      if (c_work[i]) begin
        cif.core_req[i] = spurious && ($urandom_range(7) == 0);
        if (c_cnt[i] == 0) begin
          cif.core_result_valid[i] = 1'b1;
          cif.core_result_found[i] = sec_en && (c_key[i] == sec0 || c_key[i] == sec1);
        end
      end else begin
        cif.core_req[i] = ($urandom_range(99) < req_pct);
        if (spurious && $urandom_range(15) == 0) begin
          cif.core_result_valid[i] = 1'b1;
          cif.core_result_found[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic clear_cores();
    cif.core_req = '0; cif.core_result_valid = '0; cif.core_result_found = '0;
  endtask

  // Advance model and DUT by one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    if (reset) model_reset(); else model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) begin
      if (c_work[i]) begin
        if (cif.core_result_valid[i]) c_work[i] = 0; else c_cnt[i]--;
      end
      if (e_grant[i]) begin
        c_work[i] = 1; c_key[i] = e_key; c_cnt[i] = $urandom_range(lat_hi, lat_lo);
      end
      if (e_abort || reset) c_work[i] = 0;
    end
  endtask

  task automatic begin_search(input logic [KW-1:0] s, input logic [KW-1:0] e);
    ks = s; ke = e; start = 1'b1;
    drive_cores();
    tick();
    start = 1'b0;
  endtask

  task automatic finish_search();
    done_ack = 1'b1; clear_cores(); tick(); done_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear_cores(); tick(); tick();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (found !== 1'b0) begin n_err++; $display("FAIL reset_found: got %b want 0", found); end
    n_vec++; if (found_key !== '0) begin n_err++; $display("FAIL reset_found_key: got %h want 0", found_key); end
    n_vec++; if (keys_dispatched !== '0) begin n_err++; $display("FAIL reset_dispatched: got %0d want 0", keys_dispatched); end
    n_vec++; if (cif.core_grant !== '0) begin n_err++; $display("FAIL reset_grant: got %b want 0", cif.core_grant); end
    n_vec++; if (cif.core_key !== '0) begin n_err++; $display("FAIL reset_key: got %h want 0", cif.core_key); end
    n_vec++; if (cif.core_abort !== 1'b0) begin n_err++; $display("FAIL reset_abort: got %b want 0", cif.core_abort); end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    int gidx[$], gkey[$], gcyc[$];
    req_pct = 100; lat_lo = 2; lat_hi = 20; sec_en = 0; spurious = 0;
    begin_search(24'd0, 24'd3);
    for (int cyc = 0; cyc < 80 && m_phase != 3; cyc++) begin
      drive_cores(); tick();
      for (int i = 0; i < NC; i++)
        if (cif.core_grant[i] === 1'b1) begin gidx.push_back(i); gkey.push_back(int'(cif.core_key)); gcyc.push_back(cyc); end
    end
    n_vec++; if (gidx.size() != 4) begin n_err++; $display("FAIL seq_grant_count: got %0d want 4", gidx.size()); end
    for (int k = 0; k < gidx.size() && k < 4; k++) begin
      n_vec++; if (gidx[k] != k || gkey[k] != k || gcyc[k] != gcyc[0] + k) begin
        n_err++; $display("FAIL seq_grant%0d: got core %0d key %0d cyc +%0d want core %0d key %0d cyc +%0d",
                          k, gidx[k], gkey[k], gcyc[k] - gcyc[0], k, k, k);
      end
    end
    n_vec++; if (done !== 1'b1 || found !== 1'b0) begin n_err++; $display("FAIL seq_done: got done %b found %b want 1 0", done, found); end
    n_vec++; if (keys_dispatched !== 25'd4) begin n_err++; $display("FAIL seq_dispatched: got %0d want 4", keys_dispatched); end
    finish_search();
  endtask

  task automatic test_empty_range();
    clear_cores(); begin_search(24'd5, 24'd4);
    n_vec++; if (done !== 1'b1 || found !== 1'b0 || keys_dispatched !== '0) begin
      n_err++; $display("FAIL empty_range: got done %b found %b disp %0d want 1 0 0", done, found, keys_dispatched);
    end
    cif.core_req = '1; tick();
    n_vec++; if (cif.core_grant !== '0 || done !== 1'b1) begin
      n_err++; $display("FAIL empty_no_grant: got grant %b done %b want 0 1", cif.core_grant, done);
    end
    finish_search();
  endtask

  task automatic test_found();
    int aborts = 0, late = 0;
    req_pct = 70; lat_lo = 0; lat_hi = 4; sec_en = 1; spurious = 0;
    sec0 = KW'(16 + $urandom_range(15)); sec1 = sec0;
    begin_search(24'h10, 24'h1F);
    for (int cyc = 0; cyc < 200 && m_phase != 3; cyc++) begin
      drive_cores(); tick();
      n_vec++; if (cif.core_grant !== e_grant) begin n_err++; $display("FAIL found_grant: got %b want %b", cif.core_grant, e_grant); end
      if (cif.core_abort === 1'b1) aborts++;
    end
    for (int cyc = 0; cyc < 4; cyc++) begin
      drive_cores(); tick();
      if (cif.core_abort === 1'b1) aborts++;
      if (cif.core_grant !== '0) late++;
    end
    n_vec++; if (found !== 1'b1 || found_key !== sec0) begin n_err++; $display("FAIL found_key: got %b %h want 1 %h", found, found_key, sec0); end
    n_vec++; if (aborts != 1 || late != 0) begin n_err++; $display("FAIL found_abort: got %0d aborts %0d late grants want 1 0", aborts, late); end
    finish_search();
  endtask

  task automatic test_simultaneous();
    spurious = 0; sec_en = 0;
    clear_cores(); begin_search(24'd0, 24'd7);
    for (int k = 0; k < 4; k++) begin cif.core_req = '1; tick(); end
    cif.core_req = '0; cif.core_result_valid = 4'b1010; cif.core_result_found = 4'b1010; tick();
    n_vec++; if (found !== 1'b1 || found_key !== m_assigned[1]) begin
      n_err++; $display("FAIL simul_found_key: got %b %h want 1 %h", found, found_key, m_assigned[1]);
    end
    n_vec++; if (cif.core_abort !== 1'b1 || done !== 1'b1 || keys_dispatched !== 25'd4) begin
      n_err++; $display("FAIL simul_abort: got abort %b done %b disp %0d want 1 1 4", cif.core_abort, done, keys_dispatched);
    end
    finish_search();
  endtask

  task automatic test_wrap();
    int grants = 0;
    logic [KW-1:0] want;
    req_pct = 100; lat_lo = 0; lat_hi = 3; sec_en = 0; spurious = 0;
    want = 24'hFFFFFE;
    begin_search(24'hFFFFFE, 24'hFFFFFF);
    for (int cyc = 0; cyc < 60 && (m_phase != 3 || cyc < 10); cyc++) begin
      if (m_phase == 3) clear_cores(); else drive_cores();
      tick();
      if (cif.core_grant !== '0) begin
        n_vec++; if (cif.core_key !== want) begin n_err++; $display("FAIL wrap_key: got %h want %h", cif.core_key, want); end
        want = want + 1'b1; grants++;
      end
    end
    n_vec++; if (grants != 2 || keys_dispatched !== 25'd2) begin n_err++; $display("FAIL wrap_count: got %0d grants disp %0d want 2 2", grants, keys_dispatched); end
    n_vec++; if (done !== 1'b1 || found !== 1'b0) begin n_err++; $display("FAIL wrap_done: got done %b found %b want 1 0", done, found); end
    finish_search();
  endtask

  task automatic test_stop();
    int w;
    req_pct = 80; lat_lo = 0; lat_hi = 6; sec_en = 0; spurious = 0;
    begin_search(24'h100, 24'h1FF);
    w = $urandom_range(15, 5);
    for (int cyc = 0; cyc < w; cyc++) begin drive_cores(); tick(); end
    stop = 1'b1; drive_cores(); tick(); stop = 1'b0;
    n_vec++; if (cif.core_abort !== 1'b1 || done !== 1'b1 || found !== 1'b0) begin
      n_err++; $display("FAIL stop_abort: got abort %b done %b found %b want 1 1 0", cif.core_abort, done, found);
    end
    w = $urandom_range(8, 3);
    for (int cyc = 0; cyc < w; cyc++) begin
      drive_cores(); tick();
      n_vec++; if (done !== 1'b1 || cif.core_grant !== '0 || cif.core_abort !== 1'b0 || keys_dispatched !== (KW+1)'(m_disp)) begin
        n_err++; $display("FAIL stop_hold: got done %b grant %b abort %b disp %0d want 1 0 0 %0d",
                          done, cif.core_grant, cif.core_abort, keys_dispatched, m_disp);
      end
    end
    finish_search();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL stop_ack: got done %b want 0", done); end
    cif.core_req = '1; tick();
    n_vec++; if (done !== 1'b0 || cif.core_grant !== '0) begin n_err++; $display("FAIL stop_idle: got done %b grant %b want 0 0", done, cif.core_grant); end
  endtask

  task automatic test_reset_in_drain();
    req_pct = 100; lat_lo = 10; lat_hi = 15; sec_en = 0; spurious = 0;
    begin_search(24'd0, 24'd5);
    for (int cyc = 0; cyc < 100 && m_phase != 2; cyc++) begin drive_cores(); tick(); end
    n_vec++; if (m_phase != 2 || done !== 1'b0) begin n_err++; $display("FAIL drain_reach: got phase %0d done %b want 2 0", m_phase, done); end
    reset = 1'b1; clear_cores(); tick(); reset = 1'b0;
    n_vec++; if ({done, found, cif.core_abort} !== 3'b000 || found_key !== '0 || keys_dispatched !== '0 ||
                 cif.core_grant !== '0 || cif.core_key !== '0) begin
      n_err++; $display("FAIL drain_reset: got done %b found %b abort %b fkey %h disp %0d grant %b key %h want all 0",
                        done, found, cif.core_abort, found_key, keys_dispatched, cif.core_grant, cif.core_key);
    end
    lat_lo = 0; lat_hi = 4; sec_en = 1; sec0 = 24'h23; sec1 = 24'h23;
    begin_search(24'h20, 24'h27);
    for (int cyc = 0; cyc < 200 && m_phase != 3; cyc++) begin
      drive_cores(); tick();
      n_vec++; if (cif.core_grant !== e_grant) begin n_err++; $display("FAIL drain_restart_grant: got %b want %b", cif.core_grant, e_grant); end
    end
    n_vec++; if (found !== 1'b1 || found_key !== 24'h23) begin n_err++; $display("FAIL drain_restart_found: got %b %h want 1 23", found, found_key); end
    finish_search();
  endtask

  task automatic test_random();
    for (int s = 0; s < 8; s++) begin
      int base, len, stop_at, w, hold;
      bit fin;
      base = $urandom_range(200, 1); len = $urandom_range(20);
      req_pct = 60; lat_lo = 0; lat_hi = 5; sec_en = 1; spurious = 1;
      sec0 = KW'(base + $urandom_range(len + 8)); sec1 = KW'(base + $urandom_range(len + 8));
      stop_at = ($urandom_range(3) == 0) ? $urandom_range(12, 2) : -1;
      w = $urandom_range(3); hold = 0; fin = 0;
      begin_search(KW'(base), (s == 3) ? KW'(base - 1) : KW'(base + len));
      for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
        stop = (cyc == stop_at);
        done_ack = (m_phase == 3) && (hold >= w);
        if (m_phase == 3) hold++;
        fin = done_ack;
        drive_cores(); tick();
        n_vec++; if (cif.core_grant !== e_grant) begin n_err++; $display("FAIL rnd_grant: got %b want %b", cif.core_grant, e_grant); end
        if (e_grant != 0) begin
          n_vec++; if (cif.core_key !== e_key) begin n_err++; $display("FAIL rnd_key: got %h want %h", cif.core_key, e_key); end
        end
        n_vec++; if (cif.core_abort !== e_abort) begin n_err++; $display("FAIL rnd_abort: got %b want %b", cif.core_abort, e_abort); end
        n_vec++; if (done !== (m_phase == 3)) begin n_err++; $display("FAIL rnd_done: got %b want %b", done, m_phase == 3); end
        n_vec++; if (keys_dispatched !== (KW+1)'(m_disp)) begin n_err++; $display("FAIL rnd_dispatched: got %0d want %0d", keys_dispatched, m_disp); end
        if (m_phase == 3) begin
          n_vec++; if (found !== m_found) begin n_err++; $display("FAIL rnd_found: got %b want %b", found, m_found); end
          if (m_found) begin
            n_vec++; if (found_key !== m_fkey) begin n_err++; $display("FAIL rnd_found_key: got %h want %h", found_key, m_fkey); end
          end
        end
      end
      stop = 1'b0; done_ack = 1'b0;
      if (!fin) begin n_vec++; n_err++; $display("FAIL rnd_timeout: search %0d got no done want done", s); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; done_ack = 1'b0; ks = '0; ke = '0;
    req_pct = 0; lat_lo = 0; lat_hi = 0; sec_en = 0; spurious = 0; sec0 = '0; sec1 = '0;
    for (int i = 0; i < NC; i++) begin c_work[i] = 0; c_cnt[i] = 0; c_key[i] = '0; end
    clear_cores();
    model_reset();
    test_reset();
    test_sequential();
    test_empty_range();
    test_found();
    test_simultaneous();
    test_wrap();
    test_stop();
    test_reset_in_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
